// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register of the five-stage MIPS datapath.
// Latches the WB/M/EX control bundles and decoded operands, detects load-use
// hazards against the instruction in decode, inserts a one-cycle bubble on a
// hazard or a branch flush, and keeps a saturating stall counter for debug.
module idex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [1:0]      wb_in,
    input  logic [2:0]      m_in,
    input  logic [3:0]      ex_in,
    input  logic [DW-1:0]   npc_in,
    input  logic [DW-1:0]   rdata1_in,
    input  logic [DW-1:0]   rdata2_in,
    input  logic [DW-1:0]   sext_in,
    input  logic [4:0]      rs_in,
    input  logic [4:0]      rt_in,
    input  logic [4:0]      rd_in,
    output logic [1:0]      wb_out,
    output logic [2:0]      m_out,
    output logic [3:0]      ex_out,
    output logic [DW-1:0]   npc_out,
    output logic [DW-1:0]   rdata1_out,
    output logic [DW-1:0]   rdata2_out,
    output logic [DW-1:0]   sext_out,
    output logic [4:0]      rs_out,
    output logic [4:0]      rt_out,
    output logic [4:0]      rd_out,
    output logic            valid_out,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      wb_q, wb_d;
    logic [2:0]      m_q, m_d;
    logic [3:0]      ex_q, ex_d;
    logic [DW-1:0]   npc_q, npc_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;
    logic [DW-1:0]   rdata2_q, rdata2_d;
    logic [DW-1:0]   sext_q, sext_d;
    logic [4:0]      rs_q, rs_d;
    logic [4:0]      rt_q, rt_d;
    logic [4:0]      rd_q, rd_d;
    logic            valid_q, valid_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic            hz;

    // Load-use hazard: a load in EX (MemRead) whose nonzero rt feeds decode.
    always_comb begin
        hz    = m_q[1] && (rt_q != 5'd0) && ((rt_q == rs_in) || (rt_q == rt_in));
        stall = hz && !flush;
    end

    // Next-state: flush or hazard squashes the controls; data always loads.
    always_comb begin
        wb_d        = wb_in;
        m_d         = m_in;
        ex_d        = ex_in;
        valid_d     = 1'b1;
        npc_d       = npc_in;
        rdata1_d    = rdata1_in;
        rdata2_d    = rdata2_in;
        sext_d      = sext_in;
        rs_d        = rs_in;
        rt_d        = rt_in;
        rd_d        = rd_in;
        stall_cnt_d = stall_cnt_q;
        if (flush || hz) begin
            wb_d    = 2'b00;
            m_d     = 3'b000;
            ex_d    = 4'b0000;
            valid_d = 1'b0;
        end
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Pipeline register with asynchronous clear of every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q        <= '0;
            m_q         <= '0;
            ex_q        <= '0;
            npc_q       <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            sext_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            wb_q        <= wb_d;
            m_q         <= m_d;
            ex_q        <= ex_d;
            npc_q       <= npc_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            sext_q      <= sext_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_out     = wb_q;
    assign m_out      = m_q;
    assign ex_out     = ex_q;
    assign npc_out    = npc_q;
    assign rdata1_out = rdata1_q;
    assign rdata2_out = rdata2_q;
    assign sext_out   = sext_q;
    assign rs_out     = rs_q;
    assign rt_out     = rt_q;
    assign rd_out     = rd_q;
    assign valid_out  = valid_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed and randomized checks of idex_stage against a
// behavioural model of the instruction occupying the EX slot.
module tb_idex_stage;

    localparam int DW   = 32;
    localparam int CNTW = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [1:0]      wb_in;
    logic [2:0]      m_in;
    logic [3:0]      ex_in;
    logic [DW-1:0]   npc_in, rdata1_in, rdata2_in, sext_in;
    logic [4:0]      rs_in, rt_in, rd_in;
    logic [1:0]      wb_out;
    logic [2:0]      m_out;
    logic [3:0]      ex_out;
    logic [DW-1:0]   npc_out, rdata1_out, rdata2_out, sext_out;
    logic [4:0]      rs_out, rt_out, rd_out;
    logic            valid_out;
    logic            stall;
    logic [CNTW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // What the model believes sits in EX.
    typedef struct {
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [3:0]    ex;
        logic [DW-1:0] npc, rd1, rd2, sext;
        logic [4:0]    rs, rt, rd;
        logic          valid;
    } slot_t;

    slot_t slot;
    int    exp_cnt;

    idex_stage #(.DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
        .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .sext_in(sext_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
        .npc_out(npc_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .sext_out(sext_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .valid_out(valid_out), .stall(stall), .stall_cnt(stall_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        slot = '{wb: 0, m: 0, ex: 0, npc: 0, rd1: 0, rd2: 0, sext: 0,
                 rs: 0, rt: 0, rd: 0, valid: 0};
        exp_cnt = 0;
    endtask

    // The EX instruction is a load whose nonzero destination decode reads.
    function automatic bit load_use();
        return slot.m[1] && (slot.rt != 0) && (slot.rt == rs_in || slot.rt == rt_in);
    endfunction

    task automatic apply_stimulus(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic fl);
        wb_in     = wb;
        m_in      = m;
        ex_in     = ex;
        rs_in     = rs;
        rt_in     = rt;
        rd_in     = rd;
        flush     = fl;
        npc_in    = $urandom;
        rdata1_in = $urandom;
        rdata2_in = $urandom;
        sext_in   = $urandom;
    endtask

    task automatic check_output(input string tag);
        check({tag, ".wb"},    32'(wb_out),     32'(slot.wb));
        check({tag, ".m"},     32'(m_out),      32'(slot.m));
        check({tag, ".ex"},    32'(ex_out),     32'(slot.ex));
        check({tag, ".npc"},   npc_out,         slot.npc);
        check({tag, ".rd1"},   rdata1_out,      slot.rd1);
        check({tag, ".rd2"},   rdata2_out,      slot.rd2);
        check({tag, ".sext"},  sext_out,        slot.sext);
        check({tag, ".rs"},    32'(rs_out),     32'(slot.rs));
        check({tag, ".rt"},    32'(rt_out),     32'(slot.rt));
        check({tag, ".rd"},    32'(rd_out),     32'(slot.rd));
        check({tag, ".valid"}, 32'(valid_out),  32'(slot.valid));
        check({tag, ".cnt"},   32'(stall_cnt),  32'(exp_cnt));
    endtask

    // Check stall, clock one edge, advance the model, then check the EX slot.
    task automatic run_cycle(input string tag);
        bit hz;
        #1;
        hz = load_use();
        check({tag, ".stall"}, 32'(stall), 32'(hz && !flush));
        @(posedge clk);
        if (hz && !flush && exp_cnt < CNT_MAX) exp_cnt++;
        slot.valid = !(flush || hz);
        slot.wb    = slot.valid ? wb_in : 2'b00;
        slot.m     = slot.valid ? m_in  : 3'b000;
        slot.ex    = slot.valid ? ex_in : 4'b0000;
        slot.npc   = npc_in;
        slot.rd1   = rdata1_in;
        slot.rd2   = rdata2_in;
        slot.sext  = sext_in;
        slot.rs    = rs_in;
        slot.rt    = rt_in;
        slot.rd    = rd_in;
        #1;
        check_output(tag);
    endtask

    initial begin
        int cnt_before;
        $display("[TB] start");
        model_reset();

        // Reset held: every output is zero regardless of inputs.
        rst_n = 1'b0;
        apply_stimulus(2'b11, 3'b010, 4'b1111, 5'd7, 5'd7, 5'd7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset");
        check("reset.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // lw $5 loads as a valid instruction after one edge.
        apply_stimulus(2'b11, 3'b010, 4'b0001, 5'd0, 5'd5, 5'd0, 1'b0);
        run_cycle("lw");
        check("lw.valid", 32'(valid_out), 32'd1);
        check("lw.m", 32'(m_out), 32'b010);

        // Dependent R-type: one stall, one bubble, then it proceeds.
        apply_stimulus(2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd7, 1'b0);
        #1;
        check("loaduse.stall_hi", 32'(stall), 32'd1);
        run_cycle("bubble");
        check("bubble.valid", 32'(valid_out), 32'd0);
        check("bubble.wb", 32'(wb_out), 32'd0);
        check("bubble.stall_lo", 32'(stall), 32'd0);
        run_cycle("rtype");
        check("rtype.wb", 32'(wb_out), 32'b10);
        check("rtype.valid", 32'(valid_out), 32'd1);
        check("rtype.cnt", 32'(stall_cnt), 32'd1);

        // lw to $0 never stalls.
        apply_stimulus(2'b11, 3'b010, 4'b0001, 5'd0, 5'd0, 5'd0, 1'b0);
        run_cycle("lw0");
        apply_stimulus(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd3, 1'b0);
        #1;
        check("lw0.nostall", 32'(stall), 32'd0);
        run_cycle("after_lw0");

        // sw with matching rt never stalls.
        apply_stimulus(2'b00, 3'b001, 4'b0001, 5'd1, 5'd9, 5'd0, 1'b0);
        run_cycle("sw");
        apply_stimulus(2'b10, 3'b000, 4'b1100, 5'd9, 5'd9, 5'd4, 1'b0);
        #1;
        check("sw.nostall", 32'(stall), 32'd0);
        run_cycle("after_sw");

        // Flush with a hazard present: no stall, bubble, counter unchanged.
        apply_stimulus(2'b11, 3'b010, 4'b0001, 5'd0, 5'd5, 5'd0, 1'b0);
        run_cycle("lw_fl");
        cnt_before = exp_cnt;
        apply_stimulus(2'b10, 3'b000, 4'b1100, 5'd5, 5'd1, 5'd2, 1'b1);
        #1;
        check("flush.stall", 32'(stall), 32'd0);
        run_cycle("flush");
        check("flush.wb", 32'(wb_out), 32'd0);
        check("flush.valid", 32'(valid_out), 32'd0);
        check("flush.cnt", 32'(stall_cnt), 32'(cnt_before));

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(2'($urandom), 3'($urandom), 4'($urandom),
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom), ($urandom_range(0, 7) == 0));
            run_cycle("rand");
        end

        // Asynchronous reset between edges clears outputs immediately.
        apply_stimulus(2'b11, 3'b010, 4'b0001, 5'd0, 5'd5, 5'd0, 1'b0);
        run_cycle("pre_areset");
        apply_stimulus(2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("areset");
        check("areset.stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back lw $5,0($5): stalls every other cycle until saturation.
        for (int i = 0; i < 44; i++) begin
            apply_stimulus(2'b11, 3'b010, 4'b0001, 5'd5, 5'd5, 5'd0, 1'b0);
            run_cycle("sat");
        end
        check("sat.cnt", 32'(stall_cnt), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
